// File: rtl/l1_mem_arbiter_pkg.sv
// l1_mem_arbiter_pkg: shared state encoding and default widths for the L1 memory arbiter
package l1_mem_arbiter_pkg;
  localparam int BLOCK_ADDR_W_DEF = 26;
  localparam int BLOCK_W_DEF = 256;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_IC = 2'd1, GNT_DC = 2'd2} arb_state_e;
endpackage

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one main-memory port between icache and dcache, dcache-first with icache starvation guard
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_ADDR_W = BLOCK_ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ic_ren,
  input  logic [BLOCK_ADDR_W-1:0] ic_addr,
  output logic                    ic_read_ready,
  output logic [BLOCK_W-1:0]      ic_rdata,
  input  logic                    dc_ren,
  input  logic                    dc_wen,
  input  logic [BLOCK_ADDR_W-1:0] dc_addr,
  input  logic [BLOCK_W-1:0]      dc_wdata,
  output logic                    dc_read_ready,
  output logic                    dc_write_done,
  output logic [BLOCK_W-1:0]      dc_rdata,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [BLOCK_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]      mem_din,
  input  logic [BLOCK_W-1:0]      mem_dout,
  input  logic                    mem_read_ready,
  input  logic                    mem_write_done
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  arb_state_e state, next_state;
  logic [CW-1:0] starve_cnt;
  logic dc_lock, dc_req, dc_win, in_ic, in_dc, idle;
  always_comb begin
    idle = state == IDLE;
    in_ic = state == GNT_IC;
    in_dc = state == GNT_DC;
    dc_req = dc_ren | dc_wen;
    dc_win = dc_req & (dc_lock | ~ic_ren | (starve_cnt < LIMIT));
    mem_wen = in_dc & dc_wen;
    mem_ren = in_ic ? ic_ren : in_dc ? dc_ren & ~dc_wen : 1'b0;
    mem_addr = in_ic ? ic_addr : in_dc ? dc_addr : '0;
    mem_din = in_dc ? dc_wdata : '0;
    ic_read_ready = mem_read_ready & in_ic;
    dc_read_ready = mem_read_ready & in_dc & mem_ren;
    dc_write_done = mem_write_done & in_dc & mem_wen;
    ic_rdata = mem_dout;
    dc_rdata = mem_dout;
    next_state = idle ? (dc_win ? GNT_DC : ic_ren ? GNT_IC : IDLE) :
                 in_ic ? ((mem_read_ready | ~ic_ren) ? IDLE : GNT_IC) :
                 in_dc ? ((dc_read_ready | dc_write_done | ~dc_req) ? IDLE : GNT_DC) : IDLE;
  end
  // locked grants finish a writeback+refill pair and do not count toward starvation
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      dc_lock <= 1'b0;
    end else begin
      state <= next_state;
      if (idle && (!ic_ren || next_state == GNT_IC))
        starve_cnt <= '0;
      else if (idle && next_state == GNT_DC && !dc_lock && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CW'(1);
      dc_lock <= dc_write_done ? 1'b1 : (idle && next_state == GNT_DC) ? 1'b0 : dc_lock;
    end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed vectors for the L1 memory arbiter with hand-computed expectations
module tb_l1_mem_arbiter;
  logic clock = 1'b0, reset = 1'b0;
  logic ic_ren = 0, dc_ren = 0, dc_wen = 0, mem_read_ready = 0, mem_write_done = 0;
  logic [25:0] ic_addr = 26'h0, dc_addr = 26'h0, mem_addr;
  logic [255:0] dc_wdata = '0, mem_dout = '0, mem_din, ic_rdata, dc_rdata;
  logic ic_read_ready, dc_read_ready, dc_write_done, mem_ren, mem_wen;
  int n_tests = 0, n_fail = 0;
  int dc_grants;
  bit ic_got;

  l1_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_ren(ic_ren), .ic_addr(ic_addr), .ic_read_ready(ic_read_ready), .ic_rdata(ic_rdata),
    .dc_ren(dc_ren), .dc_wen(dc_wen), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_read_ready(dc_read_ready), .dc_write_done(dc_write_done), .dc_rdata(dc_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_read_ready(mem_read_ready), .mem_write_done(mem_write_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_strobes", {ic_read_ready, dc_read_ready, dc_write_done}, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    chk("rst_lock", dut.dc_lock, 0);
    tick(); reset = 1;

    // 1: lone dcache read, memory answers on the third granted cycle
    tick(); dc_ren = 1; dc_addr = 26'h0A1; #1;
    chk("t1_idle_ren", mem_ren, 0);
    tick(); #1;
    chk("t1_ren_c1", mem_ren, 1);
    chk("t1_addr", mem_addr, 26'h0A1);
    chk("t1_rdy_early", dc_read_ready, 0);
    tick(); #1;
    chk("t1_ren_c2", mem_ren, 1);
    tick(); mem_read_ready = 1; mem_dout = 256'hD1D1; #1;
    chk("t1_ren_c3", mem_ren, 1);
    chk("t1_dc_rdy", dc_read_ready, 1);
    chk("t1_ic_rdy", ic_read_ready, 0);
    chk("t1_rdata", dc_rdata, 256'hD1D1);
    tick(); mem_read_ready = 0; dc_ren = 0; #1;
    chk("t1_back_idle", mem_ren, 0);

    // 2: simultaneous requests, dcache wins, icache after one idle cycle
    tick(); ic_ren = 1; ic_addr = 26'h1C0; dc_ren = 1; dc_addr = 26'h2D0;
    tick(); mem_read_ready = 1; #1;
    chk("t2_dc_first", mem_addr, 26'h2D0);
    chk("t2_ic_rdy_blk", ic_read_ready, 0);
    chk("t2_dc_rdy", dc_read_ready, 1);
    tick(); mem_read_ready = 0; dc_ren = 0; #1;
    chk("t2_turnaround", mem_ren, 0);
    tick(); mem_read_ready = 1; mem_dout = 256'hD2; #1;
    chk("t2_ic_ren", mem_ren, 1);
    chk("t2_ic_addr", mem_addr, 26'h1C0);
    chk("t2_ic_rdy", ic_read_ready, 1);
    chk("t2_ic_rdata", ic_rdata, 256'hD2);
    chk("t2_dc_rdy_blk", dc_read_ready, 0);
    tick(); mem_read_ready = 0; ic_ren = 0;

    // 3: writeback then refill stay atomic against a waiting icache
    tick(); ic_ren = 1; dc_wen = 1; dc_addr = 26'h333; dc_wdata = 256'hBEEF;
    tick(); mem_write_done = 1; #1;
    chk("t3_wen", mem_wen, 1);
    chk("t3_ren", mem_ren, 0);
    chk("t3_din", mem_din, 256'hBEEF);
    chk("t3_wdone", dc_write_done, 1);
    tick(); mem_write_done = 0; dc_wen = 0; dc_ren = 1; #1;
    chk("t3_idle", {mem_ren, mem_wen}, 0);
    chk("t3_lock_set", dut.dc_lock, 1);
    tick(); mem_read_ready = 1; #1;
    chk("t3_refill_addr", mem_addr, 26'h333);
    chk("t3_refill_ren", mem_ren, 1);
    chk("t3_lock_nocount", dut.starve_cnt, 1);
    chk("t3_lock_clr", dut.dc_lock, 0);
    chk("t3_refill_rdy", dc_read_ready, 1);
    tick(); mem_read_ready = 0; dc_ren = 0;
    tick(); mem_read_ready = 1; #1;
    chk("t3_ic_addr", mem_addr, 26'h1C0);
    chk("t3_ic_rdy", ic_read_ready, 1);
    tick(); mem_read_ready = 0; ic_ren = 0;

    // 4: back-to-back dcache reads starve icache for exactly STARVE_LIMIT grants
    tick(); ic_ren = 1; dc_ren = 1; dc_addr = 26'h444;
    dc_grants = 0; ic_got = 0;
    for (int i = 0; i < 40 && !ic_got; i++) begin
      tick(); mem_read_ready = 0; #1;
      if (mem_ren && mem_addr == 26'h444) begin
        dc_grants++;
        mem_read_ready = 1;
      end else if (mem_ren && mem_addr == 26'h1C0) ic_got = 1;
    end
    chk("t4_dc_grants", dc_grants, 4);
    chk("t4_ic_granted", ic_got, 1);
    chk("t4_starve_clr", dut.starve_cnt, 0);
    mem_read_ready = 1; #1;
    chk("t4_ic_rdy", ic_read_ready, 1);
    tick(); mem_read_ready = 0; ic_ren = 0; dc_ren = 0;

    // stray pulses in IDLE go nowhere
    tick(); mem_read_ready = 1; mem_write_done = 1; #1;
    chk("idle_stray", {ic_read_ready, dc_read_ready, dc_write_done}, 0);
    tick(); mem_read_ready = 0; mem_write_done = 0;

    // 5: read and write both requested, write wins; a read pulse is the wrong op
    tick(); dc_ren = 1; dc_wen = 1; dc_addr = 26'h555; dc_wdata = 256'hCAFE;
    tick(); mem_read_ready = 1; #1;
    chk("t5_wen", mem_wen, 1);
    chk("t5_ren", mem_ren, 0);
    chk("t5_din", mem_din, 256'hCAFE);
    chk("t5_wrong_op", dc_read_ready, 0);
    tick(); mem_read_ready = 0; mem_write_done = 1; #1;
    chk("t5_still_gnt", mem_wen, 1);
    chk("t5_wdone", dc_write_done, 1);
    tick(); mem_write_done = 0; dc_ren = 0; dc_wen = 0;

    // icache abort: request drop releases memory, late pulse dropped
    tick(); ic_ren = 1; ic_addr = 26'h1C1;
    tick(); #1;
    chk("ab_ren", mem_ren, 1);
    ic_ren = 0; #1;
    chk("ab_drop", mem_ren, 0);
    tick(); mem_read_ready = 1; #1;
    chk("ab_late", ic_read_ready, 0);
    tick(); mem_read_ready = 0;

    // 6: asynchronous reset mid dcache read
    tick(); dc_ren = 1; dc_addr = 26'h666;
    tick(); #1;
    chk("t6_ren_pre", mem_ren, 1);
    #1 reset = 0; #1;
    chk("t6_ren_async", mem_ren, 0);
    chk("t6_lock_rst", dut.dc_lock, 0);
    tick(); dc_ren = 0; reset = 1; mem_read_ready = 1; #1;
    chk("t6_stray_dc", dc_read_ready, 0);
    chk("t6_stray_ic", ic_read_ready, 0);
    tick(); mem_read_ready = 0; #1;
    chk("t6_idle", mem_ren, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
